// File: rtl/multiport_mem_pkg.sv
// Shared types and helpers for the multi-port data memory.
// byte_merge works on a maximum-width word so every DATA_W instance can share it.
package multiport_mem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BE_W       = DEF_DATA_W / 8;
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef logic [MAX_DATA_W-1:0] word_t;

  // Bytes with be[i]=1 come from new_w, all others from old_w.
  function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                       input logic [MAX_BE_W-1:0] be);
    word_t res;
    res = old_w;
    for (int unsigned i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/multiport_mem_read_port.sv
// One registered read port: range check, write-first forwarding and output register.
module mem_read_port
  import multiport_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic                  r_en,
  input  logic [ADDR_W-1:0]     r_adrs,
  input  logic                  w_en,
  input  logic [ADDR_W-1:0]     w_adrs,
  input  logic [DATA_W/8-1:0]   w_be,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W-1:0]     mem_word,
  output logic [DATA_W-1:0]     data_out,
  output logic                  r_valid,
  output logic                  range_err
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              in_range;
  logic              hit;
  logic [DATA_W-1:0] next_word;

  assign in_range = {1'b0, r_adrs} < DEPTH_X;
  assign hit      = w_en && in_range && (r_adrs == w_adrs);

  always_comb begin
    next_word = mem_word;
    if (!in_range) next_word = '0;
    else if (hit)
      next_word = DATA_W'(byte_merge(word_t'(mem_word), word_t'(data_in), MAX_BE_W'(w_be)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      r_valid   <= 1'b0;
      range_err <= 1'b0;
    end else if (ready && r_en) begin
      data_out  <= next_word;
      r_valid   <= 1'b1;
      range_err <= !in_range;
    end else begin
      r_valid   <= 1'b0;
      range_err <= 1'b0;
    end
  end

endmodule

// File: rtl/multiport_mem.sv
// Byte-enabled 1-write / NUM_RD-read data memory with a post-reset clear sweep.
module multiport_mem
  import multiport_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_en,
  input  logic [ADDR_W-1:0]          w_adrs,
  input  logic [DATA_W/8-1:0]        w_be,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [NUM_RD-1:0]          r_en,
  input  logic [NUM_RD*ADDR_W-1:0]   r_adrs,
  output logic [NUM_RD*DATA_W-1:0]   data_out,
  output logic [NUM_RD-1:0]          r_valid,
  output logic                       busy,
  output logic                       addr_err
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready;
  logic              w_in_range;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_word;
  logic [NUM_RD-1:0] port_err;

  assign ready      = (state == READY);
  assign w_in_range = {1'b0, w_adrs} < DEPTH_X;
  assign w_idx      = w_adrs[IDX_W-1:0];
  assign w_word     = DATA_W'(byte_merge(word_t'(mem[w_idx]), word_t'(data_in), MAX_BE_W'(w_be)));
  assign addr_err   = w_err | (|port_err);

  // busy is a registered copy of CLEAR so it falls on the edge that writes DEPTH-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
      w_err   <= 1'b0;
    end else begin
      w_err <= 1'b0;
      unique case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        READY: w_err <= w_en && !w_in_range;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_cnt[IDX_W-1:0]] <= '0;
    else if (w_en && w_in_range) mem[w_idx] <= w_word;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] word;

    assign adrs = r_adrs[k*ADDR_W +: ADDR_W];
    assign word = mem[adrs[IDX_W-1:0]];

    mem_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .ready     (ready),
      .r_en      (r_en[k]),
      .r_adrs    (adrs),
      .w_en      (w_en),
      .w_adrs    (w_adrs),
      .w_be      (w_be),
      .data_in   (data_in),
      .mem_word  (word),
      .data_out  (data_out[k*DATA_W +: DATA_W]),
      .r_valid   (r_valid[k]),
      .range_err (port_err[k])
    );
  end

endmodule

// File: doc/multiport_mem.md
Name: multiport_mem

Overview:
- Parametrised successor to the CPU's 1-write/2-read data memory.
- Provides one byte-enabled write port and NUM_RD independent registered read ports.
- Read ports give write-first forwarding on same-address collisions and report accesses beyond DEPTH.
- After reset, a clear sequencer zeroes the whole array before accepting traffic. The block sits between the pipeline's MEM stage and the register-load path.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 11, address width per port.
- DEPTH, 2048, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
- NUM_RD, 2, number of read ports, 1..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- w_en  input  1  write request.
- w_adrs  input  ADDR_W  write address.
- w_be  input  DATA_W/8  byte write enables; bit i covers data_in[8i+7:8i].
- data_in  input  DATA_W  write data.
- r_en  input  NUM_RD  per-port read request.
- r_adrs  input  NUM_RD*ADDR_W  packed read addresses; port k occupies [k*ADDR_W +: ADDR_W].
- data_out  output  NUM_RD*DATA_W  packed registered read data; port k occupies [k*DATA_W +: DATA_W].
- r_valid  output  NUM_RD  data_out slice for port k is valid this cycle.
- busy  output  1  clear sequence in progress; all requests are ignored.
- addr_err  output  1  one-cycle pulse when any accepted access is at an address >= DEPTH.

Behaviour:
- Reset (async assert):
  - data_out=0, r_valid=0, addr_err=0, busy=1.
  - FSM=CLEAR, clear counter=0.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt++. When cnt==DEPTH-1 is written, go to READY. busy stays 1 through the cycle that writes DEPTH-1 and drops to 0 on the next edge. Total clear time is DEPTH cycles after reset deasserts.
  - READY: normal operation. No exit except reset.
- Reset asserted mid-CLEAR restarts the sweep from address 0.
- While busy=1:
  - w_en and r_en are ignored.
  - r_valid=0, data_out holds 0.
  - addr_err=0.
- Write (READY, w_en=1, w_adrs<DEPTH):
  - On the edge, mem[w_adrs] byte i <= data_in byte i for each w_be[i]=1.
  - w_be=0 is a legal no-op write.
- Read (READY, r_en[k]=1), latency 1 cycle:
  - data_out slice k and r_valid[k]=1 update on the next edge.
  - If r_en[k]=0, r_valid[k]=0 next cycle and data_out slice k holds its last value.
- Collision, same edge with w_en=1, r_en[k]=1, r_adrs[k]==w_adrs<DEPTH: write-first forwarding.
  - Enabled bytes come from data_in.
  - Disabled bytes come from the old array word.
- Multiple read ports may read the same address in the same cycle; each returns identical data.
- Out-of-range access (address >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with r_valid=1.
  - addr_err pulses high for one cycle, registered with the read data.
- Address arithmetic is unsigned and never wraps; truncating to DEPTH is forbidden.

Decomposition:
- Package multiport_mem_pkg:
  - FSM state typedef with CLEAR=1'b0 and READY=1'b1.
  - Function byte_merge(old, new, be) used by both the write path and forwarding.
  - Localparam BE_W = DATA_W/8.
- Sub-module mem_read_port, one instance per port (generate loop). It holds the output register, r_valid flop, forwarding mux and range check.
- The top level owns the array, write path, clear FSM and OR-reduction of per-port range errors into addr_err.

Test Plan:
- Reset then clear: deassert reset and wait 2048 cycles. busy=1 for exactly 2048 cycles after deassertion. Then read addresses 0, 1023 and 2047 on both ports, each returning 0 with r_valid=1 one cycle later.
- Byte write: write 0xAABBCCDD to 0x045 with w_be=4'b1111, then 0x11223344 with w_be=4'b0101. Reading 0x045 next cycle returns 0xAA22CC44.
- Collision forwarding: mem[0x001]=0x0000000F. In the same cycle write 0xFFFF0000 with be=4'b1100 and read 0x001 on port 0. Port 0 returns 0xFFFF000F.
- Dual read and hold: with DEPTH=2000, read 0x7FF on port 0 and 0x7CF on port 1 in the same cycle. Next cycle data_out=0 on both, r_valid=2'b11, addr_err=1. The following idle cycle gives r_valid=2'b00, data_out unchanged and addr_err=0.
- Mid-clear reset: pulse reset at clear count 500. busy stays high and the sweep restarts, so busy falls exactly 2048 cycles after the second deassertion. A write attempted while busy leaves the target at 0.
